down_counter: RTL and testbench

Loadable, pausable down counter that counts a loaded value down to zero and flags expiry. It is the counterpart to the existing up counter in the adder datapath. The up counter counts toward rollover; this block counts a programmed delay out, giving the sequencing logic "N enabled cycles have elapsed" timing. An optional auto-reload mode turns it into a periodic tick generator.

---
 rtl/down_counter_pkg.sv | 11 +
 rtl/down_counter.sv | 90 +++++++++
 tb/tb_down_counter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/down_counter_pkg.sv
// Shared definitions for the down counter: controller states and default width.
package down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable, pausable down counter with registered expiry pulse and optional
// auto-reload for periodic ticks.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no delay in progress; count holds, en/auto ignored
// ST_RUN  | counting a loaded delay down on each enabled edge
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] val,
    input  logic             load,
    input  logic             en,
    input  logic             auto,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             Z
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             z_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            count  <= '0;
            reload <= '0;
            Z      <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            reload <= reload_nxt;
            Z      <= z_nxt;
        end
    end

    // A load always wins; a zero load is an immediate expiry.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload;
        z_nxt      = 1'b0;
        if (load) begin
            count_nxt  = val;
            reload_nxt = val;
            if (val != '0) begin
                state_nxt = ST_RUN;
            end else begin
                state_nxt = ST_IDLE;
                z_nxt     = 1'b1;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (en) begin
                        if (count > ONE) begin
                            count_nxt = count - ONE;
                        end else begin
                            z_nxt = 1'b1;
                            if (auto && (reload != '0)) begin
                                count_nxt = reload;
                            end else begin
                                count_nxt = '0;
                                state_nxt = ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy = (state == ST_RUN);
    end

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter: per-cycle comparison against a behavioural
// model plus literal expectations for each scenario.
module tb_down_counter;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         load  = 1'b0;
    logic         en    = 1'b0;
    logic         auto  = 1'b0;
    logic [W-1:0] val   = '0;
    logic [W-1:0] count;
    logic         busy;
    logic         Z;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    int m_cnt = 0;
    int m_rel = 0;
    bit m_run = 1'b0;
    bit m_z   = 1'b0;

    down_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .val   (val),
        .load  (load),
        .en    (en),
        .auto  (auto),
        .count (count),
        .busy  (busy),
        .Z     (Z)
    );

    always #5 clk = ~clk;

    // Model: remaining delay, period, and whether a delay is pending.
    always @(posedge clk) begin
        m_z = 1'b0;
        if (!rst_n) begin
            m_cnt = 0;
            m_rel = 0;
            m_run = 1'b0;
        end else if (load) begin
            m_cnt = int'(val);
            m_rel = int'(val);
            m_run = (val != 0);
            m_z   = (val == 0);
        end else if (m_run && en) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_z = 1'b1;
                if (auto && m_rel != 0) m_cnt = m_rel;
                else m_run = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("model_count", int'(count), m_cnt);
            chk("model_busy", int'(busy), int'(m_run));
            chk("model_z", int'(Z), int'(m_z));
        end
    end

    task automatic step(input bit l, input int v, input bit e, input bit a);
        load = l;
        val  = v[W-1:0];
        en   = e;
        auto = a;
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string name, input int c, input bit b, input bit z);
        chk({name, "_count"}, int'(count), c);
        chk({name, "_busy"}, int'(busy), int'(b));
        chk({name, "_z"}, int'(Z), int'(z));
    endtask

    int basic_c[7] = '{5, 4, 3, 2, 1, 0, 0};
    bit basic_z[7] = '{0, 0, 0, 0, 0, 1, 0};
    bit stall_e[6] = '{1, 0, 0, 1, 1, 1};
    int stall_c[6] = '{3, 3, 3, 2, 1, 0};
    int auto_c[9]  = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    bit auto_z[9]  = '{0, 0, 1, 0, 0, 1, 0, 0, 1};

    initial begin
        // reset overrides a pending load
        rst_n = 1'b0;
        step(1, 9, 1, 0);
        checking = 1'b1;
        expect3("reset1", 0, 0, 0);
        step(1, 9, 1, 0);
        expect3("reset2", 0, 0, 0);
        rst_n = 1'b1;

        // basic count
        step(1, 6, 1, 0);
        expect3("basic_load", 6, 1, 0);
        chk("pin_model_load", m_cnt, 6);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, 0);
            expect3("basic", basic_c[i], (i < 5), basic_z[i]);
        end

        // stall
        step(1, 4, 1, 0);
        expect3("stall_load", 4, 1, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, stall_e[i], 0);
            expect3("stall", stall_c[i], (i < 5), (i == 5));
        end

        // auto reload
        step(1, 3, 1, 1);
        expect3("auto_load", 3, 1, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 1, 1);
            expect3("auto", auto_c[i], 1, auto_z[i]);
        end
        chk("pin_model_period", m_rel, 3);

        // load collides with expiry edge
        step(0, 0, 1, 1);
        expect3("coll_pre2", 2, 1, 0);
        step(0, 0, 1, 1);
        expect3("coll_pre1", 1, 1, 0);
        step(1, 5, 1, 1);
        expect3("coll_load5", 5, 1, 0);
        step(1, 0, 1, 1);
        expect3("coll_load0", 0, 0, 1);
        step(0, 0, 1, 1);
        expect3("coll_after0", 0, 0, 0);

        // auto dropped before expiry ends the run
        step(1, 2, 1, 1);
        expect3("tog_load", 2, 1, 0);
        step(0, 0, 1, 1);
        expect3("tog_1", 1, 1, 0);
        step(0, 0, 1, 0);
        expect3("tog_exp", 0, 0, 1);

        // shortest delay
        step(1, 1, 0, 0);
        expect3("one_load", 1, 1, 0);
        step(0, 0, 0, 0);
        expect3("one_hold", 1, 1, 0);
        step(0, 0, 1, 0);
        expect3("one_exp", 0, 0, 1);

        // reset mid-run, then stays idle
        step(1, 5, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        expect3("mid_pre", 3, 1, 0);
        rst_n = 1'b0;
        step(0, 0, 1, 1);
        expect3("mid_rst", 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1);
            expect3("mid_idle", 0, 0, 0);
        end
        chk("pin_model_rel_rst", m_rel, 0);

        @(negedge clk);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
